// File: rtl/program_loader_if.sv
// Bundles the byte-stream handshake, CPU pass-through bus, RAM port and status
// lines shared between the boot loader and its surroundings.
interface program_loader_if #(
   parameter int SIZE = 10
);
   logic [7:0]      rx_data;
   logic            rx_valid;
   logic            rx_ready;
   logic            cpu_wrEn;
   logic [SIZE-1:0] cpu_addr;
   logic [31:0]     cpu_data;
   logic            ram_wrEn;
   logic [SIZE-1:0] ram_addr;
   logic [31:0]     ram_data;
   logic            cpu_rst;
   logic            done;
   logic            error;

   // Loader side: consumes the byte stream and CPU bus, drives RAM and status.
   modport slave (
      input  rx_data, rx_valid, cpu_wrEn, cpu_addr, cpu_data,
      output rx_ready, ram_wrEn, ram_addr, ram_data, cpu_rst, done, error
   );

   modport master (
      output rx_data, rx_valid, cpu_wrEn, cpu_addr, cpu_data,
      input  rx_ready, ram_wrEn, ram_addr, ram_data, cpu_rst, done, error
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed image over a byte stream, writes it to
// RAM from address 0, verifies an XOR checksum, then hands RAM over to the CPU.
module program_loader #(
   parameter int SIZE  = 10,
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             rst,
   program_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_LEN_HI,
      ST_LEN_LO,
      ST_LOAD,
      ST_WRITE,
      ST_CHECK,
      ST_RUN,
      ST_ERROR
   } state_t;

   state_t        r_state;
   logic [15:0]   r_len;
   logic [SIZE:0] r_wordIdx;
   logic [1:0]    r_byteIdx;
   logic [7:0]    r_csum;
   logic [31:0]   r_asm;

   logic          w_rxReady;
   logic          w_accept;
   logic [15:0]   w_lenFull;
   logic [15:0]   w_nextIdx;

   assign w_rxReady = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                      (r_state == ST_LOAD)   || (r_state == ST_CHECK);
   assign w_accept  = bus.rx_valid && w_rxReady;
   assign w_lenFull = {r_len[15:8], bus.rx_data};
   assign w_nextIdx = 16'(r_wordIdx) + 16'd1;

   // Word index is one bit wider than the address so a full-depth image fits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_LEN_HI;
         r_len     <= '0;
         r_wordIdx <= '0;
         r_byteIdx <= '0;
         r_csum    <= '0;
         r_asm     <= '0;
      end else begin
         case (r_state)
            ST_LEN_HI: begin
               if (w_accept) begin
                  r_len[15:8] <= bus.rx_data;
                  r_state     <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (w_accept) begin
                  r_len     <= w_lenFull;
                  r_wordIdx <= '0;
                  r_byteIdx <= '0;
                  r_csum    <= '0;
                  if (w_lenFull > 16'(DEPTH))
                     r_state <= ST_ERROR;
                  else if (w_lenFull == 16'd0)
                     r_state <= ST_CHECK;
                  else
                     r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_accept) begin
                  r_asm     <= {r_asm[23:0], bus.rx_data};
                  r_csum    <= r_csum ^ bus.rx_data;
                  r_byteIdx <= r_byteIdx + 2'd1;
                  if (r_byteIdx == 2'd3)
                     r_state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               r_wordIdx <= r_wordIdx + 1'b1;
               if (w_nextIdx == r_len)
                  r_state <= ST_CHECK;
               else
                  r_state <= ST_LOAD;
            end
            ST_CHECK: begin
               if (w_accept) begin
                  if (bus.rx_data == r_csum)
                     r_state <= ST_RUN;
                  else
                     r_state <= ST_ERROR;
               end
            end
            ST_RUN:   r_state <= ST_RUN;
            ST_ERROR: r_state <= ST_ERROR;
            default:  r_state <= ST_ERROR;
         endcase
      end
   end

   // Outputs decode the registered state; only RUN lets the CPU bus reach RAM.
   always_comb begin
      bus.rx_ready = w_rxReady;
      bus.ram_wrEn = 1'b0;
      bus.ram_addr = '0;
      bus.ram_data = '0;
      bus.cpu_rst  = 1'b1;
      bus.done     = 1'b0;
      bus.error    = 1'b0;
      case (r_state)
         ST_WRITE: begin
            bus.ram_wrEn = 1'b1;
            bus.ram_addr = r_wordIdx[SIZE-1:0];
            bus.ram_data = r_asm;
         end
         ST_RUN: begin
            bus.ram_wrEn = bus.cpu_wrEn;
            bus.ram_addr = bus.cpu_addr;
            bus.ram_data = bus.cpu_data;
            bus.cpu_rst  = 1'b0;
            bus.done     = 1'b1;
         end
         ST_ERROR: bus.error = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader between a byte-stream source (UART receiver) and the 32-bit block RAM shared with the CPU.
- Holds the CPU in reset, receives a length-prefixed program image, and writes it word by word into RAM from address 0.
- Verifies an XOR checksum, then hands the RAM port over to the CPU and releases CPU reset.

Parameters:
- SIZE, 10, RAM address width in bits.
- DEPTH, 1024, RAM depth in words; the maximum loadable word count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- cpu_wrEn  input  1  CPU write enable (pass-through).
- cpu_addr  input  SIZE  CPU RAM address (pass-through).
- cpu_data  input  32  CPU write data (pass-through).
- ram_wrEn  output  1  write enable to RAM.
- ram_addr  output  SIZE  address to RAM.
- ram_data  output  32  write data to RAM.
- cpu_rst  output  1  reset to the CPU, active-high.
- done  output  1  load completed and checksum passed.
- error  output  1  load failed; sticky until rst.

Behaviour:
- Byte transfer: a byte is accepted on a rising edge where rx_valid and rx_ready are both 1. rx_ready is combinational from state: 1 in LEN_HI, LEN_LO, LOAD and CHECK; 0 in all other states.
- Stream format, all multi-byte fields big-endian:
  - word count N: 16 bits, high byte then low byte;
  - N words of 4 bytes each, most significant byte first;
  - 1 checksum byte, equal to the XOR of all 4N payload bytes (header bytes excluded).
- States: LEN_HI, LEN_LO, LOAD, WRITE, CHECK, RUN, ERROR.
  - LEN_HI: accept byte into len[15:8], then go to LEN_LO.
  - LEN_LO: accept byte into len[7:0]. Using the full 16-bit length:
    - if len > DEPTH, go to ERROR;
    - if len == 0, go to CHECK;
    - otherwise go to LOAD with word_idx=0, byte_idx=0, csum=0.
  - LOAD: each accepted byte shifts into a 32-bit assembly register (shift left by 8, byte enters at bits [7:0]), is XORed into csum, and increments byte_idx (2 bits). The edge that accepts the byte with byte_idx==3 moves the state to WRITE.
  - WRITE: one cycle. ram_wrEn=1, ram_addr=word_idx, ram_data=assembly register. Next edge: word_idx+1; go to CHECK if word_idx+1 == len, else back to LOAD.
  - CHECK: accept one byte. Equal to csum -> RUN; mismatch -> ERROR.
  - RUN: terminal. ram_wrEn/ram_addr/ram_data = cpu_wrEn/cpu_addr/cpu_data (combinational mux); cpu_rst=0; done=1.
  - ERROR: terminal until rst. error=1, cpu_rst=1, ram_wrEn=0, rx_ready=0, input bytes ignored.
- In all states except RUN: the ram_* outputs come from the loader (ram_wrEn=0, ram_addr=0, ram_data=0 outside WRITE), cpu_rst=1, and cpu_* inputs are ignored.
- Address widths: word_idx is SIZE+1 bits, so len == DEPTH is legal and the last write goes to DEPTH-1.
- Latency: the 4th byte of a word is accepted at edge k; RAM samples the write at edge k+1. The checksum byte is accepted at edge m; done=1 and cpu_rst=0 hold from edge m onward.
- Reset values (rst=1 at an edge): state=LEN_HI, len/word_idx/byte_idx/csum/assembly register = 0.
  - Outputs after reset: rx_ready=1, ram_wrEn=0, ram_addr=0, ram_data=0, cpu_rst=1, done=0, error=0.
  - rst has priority over an accepted byte in the same cycle.
- Reset mid-load: returns to LEN_HI immediately. RAM contents already written stay (not erased); a new image overwrites them from address 0.
- A failed checksum leaves the written words in RAM, but the CPU is never released.
- rx_valid while rx_ready=0: the byte is not consumed; the source must hold it.

Test Plan:
- Bytes 00 02 20 11 40 45 10 11 40 01 74 with rx_valid held 1 -> exactly two ram_wrEn pulses (addr0=0x20114045, addr1=0x10114001); done=1, cpu_rst=0, error=0 after the 0x74 byte.
- Same stream with checksum 0x75 -> both writes occur; error=1, done=0, cpu_rst stays 1; later rx_valid bytes ignored (rx_ready=0).
- Bytes 00 00 00 -> no writes; done=1. Bytes 00 00 01 -> error=1.
- Header 04 01 (N=1025) -> error=1 right after the low byte, no writes. Header 04 00 followed by 4096 bytes + correct checksum -> last write to addr 1023, done=1.
- After done: drive cpu_wrEn=1, cpu_addr=5, cpu_data=0xDEADBEEF -> same values appear on ram_* in the same cycle.
- Assert rst after 6 payload bytes, then send the full valid 2-word stream -> correct writes, done=1. Also gap rx_valid randomly -> identical result.
